pc_update_64: RTL and testbench



---
 rtl/pc_update_64.sv | 68 ++++++
 tb/tb_pc_update_64.sv | 136 +++++++++++++
 2 files changed

// File: rtl/pc_update_64.sv
// PC-update stage for SEQ Y86-64: picks valP/valC/valM by icode/cnd and registers it.
// Optional feature: define PC_UPDATE_HALT_STICKY_EN to freeze the PC after a halt until reset.
module pc_update_64 #(
    parameter int                 ADDR_W   = 64,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        icode,
    input  logic [ADDR_W-1:0] valC,
    input  logic [ADDR_W-1:0] valM,
    input  logic [ADDR_W-1:0] valP,
    input  logic              cnd,
    output logic [ADDR_W-1:0] new_pc
);

    localparam logic [3:0] I_HALT   = 4'd0;
    localparam logic [3:0] I_NOP    = 4'd1;
    localparam logic [3:0] I_CMOV   = 4'd2;
    localparam logic [3:0] I_IRMOV  = 4'd3;
    localparam logic [3:0] I_RMMOV  = 4'd4;
    localparam logic [3:0] I_MRMOV  = 4'd5;
    localparam logic [3:0] I_OPQ    = 4'd6;
    localparam logic [3:0] I_JXX    = 4'd7;
    localparam logic [3:0] I_CALL   = 4'd8;
    localparam logic [3:0] I_RET    = 4'd9;
    localparam logic [3:0] I_PUSH   = 4'd10;
    localparam logic [3:0] I_POP    = 4'd11;

    logic [ADDR_W-1:0] next_pc;

    // Unlisted or unknown codes fall to the default arm, which holds the current PC.
    always_comb begin
        next_pc = new_pc;
        case (icode)
            I_HALT, I_NOP, I_CMOV, I_IRMOV, I_RMMOV,
            I_MRMOV, I_OPQ, I_PUSH, I_POP: next_pc = valP;
            I_JXX:                         next_pc = cnd ? valC : valP;
            I_CALL:                        next_pc = valC;
            I_RET:                         next_pc = valM;
            default:                       next_pc = new_pc;
        endcase
    end

`ifdef PC_UPDATE_HALT_STICKY_EN
    logic halted;

    always_ff @(posedge clk) begin
        if (reset) begin
            halted <= 1'b0;
            new_pc <= RESET_PC;
        end else if (halted || (icode == I_HALT)) begin
            halted <= 1'b1;
        end else begin
            new_pc <= next_pc;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            new_pc <= RESET_PC;
        end else begin
            new_pc <= next_pc;
        end
    end
`endif

endmodule

// File: tb/tb_pc_update_64.sv
// Bench for pc_update_64: directed literal checks plus randomized traffic against a behavioural model.
module tb_pc_update_64;

    localparam int ADDR_W = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [3:0]        icode = 4'd1;
    logic [ADDR_W-1:0] valC = '0;
    logic [ADDR_W-1:0] valM = '0;
    logic [ADDR_W-1:0] valP = '0;
    logic              cnd = 1'b0;
    logic [ADDR_W-1:0] new_pc;

    int errors = 0;
    int checks = 0;

    logic [ADDR_W-1:0] model_pc = '0;
    logic              model_halted = 1'b0;
    logic              model_valid = 1'b0;

    pc_update_64 #(.ADDR_W(ADDR_W), .RESET_PC('0)) dut (
        .clk    (clk),
        .reset  (reset),
        .icode  (icode),
        .valC   (valC),
        .valM   (valM),
        .valP   (valP),
        .cnd    (cnd),
        .new_pc (new_pc)
    );

    always #5 clk = ~clk;

    // Reference: what the next PC must be for a given instruction, from the ISA rules.
    function automatic logic [ADDR_W-1:0] ref_next(input logic [3:0] ic, input logic c,
                                                   input logic [ADDR_W-1:0] vc,
                                                   input logic [ADDR_W-1:0] vm,
                                                   input logic [ADDR_W-1:0] vp,
                                                   input logic [ADDR_W-1:0] cur);
        int code;
        code = int'(ic);
        if (code == 7)      return c ? vc : vp;
        if (code == 8)      return vc;
        if (code == 9)      return vm;
        if (code <= 11)     return vp;
        return cur;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            model_pc     = '0;
            model_halted = 1'b0;
            model_valid  = 1'b1;
        end else if (model_valid) begin
`ifdef PC_UPDATE_HALT_STICKY_EN
            if (icode == 4'd0) model_halted = 1'b1;
            if (!model_halted) model_pc = ref_next(icode, cnd, valC, valM, valP, model_pc);
`else
            model_pc = ref_next(icode, cnd, valC, valM, valP, model_pc);
`endif
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            checks++;
            if (new_pc !== model_pc) begin
                errors++;
                $display("FAIL model_cmp t=%0t new_pc=%h expected=%h", $time, new_pc, model_pc);
            end
        end
    end

    task automatic drive(input logic r, input logic [3:0] ic, input logic c,
                         input logic [ADDR_W-1:0] vp, input logic [ADDR_W-1:0] vc,
                         input logic [ADDR_W-1:0] vm);
        @(negedge clk);
        reset = r;
        icode = ic;
        cnd   = c;
        valP  = vp;
        valC  = vc;
        valM  = vm;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pc(input string name, input logic [ADDR_W-1:0] want);
        checks++;
        if (new_pc !== want) begin
            errors++;
            $display("FAIL %s new_pc=%h expected=%h", name, new_pc, want);
        end
    endtask

    logic [ADDR_W-1:0] ones;

    initial begin
        ones = '1;
        drive(1, 4'd1, 0, 64'd55, 64'd66, 64'd77);   expect_pc("reset", 64'd0);
        drive(0, 4'd1, 0, 64'd1, 64'd0, 64'd0);      expect_pc("nop_first", 64'd1);
`ifdef PC_UPDATE_HALT_STICKY_EN
        drive(0, 4'd1, 0, 64'd5, 64'd0, 64'd0);      expect_pc("nop_pre_halt", 64'd5);
        drive(0, 4'd0, 0, 64'd112, 64'd100, 64'd17); expect_pc("halt_hold", 64'd5);
        drive(0, 4'd8, 0, 64'd11, 64'd22, 64'd33);   expect_pc("halt_ignore_call", 64'd5);
        drive(0, 4'd7, 1, 64'd1, 64'd2, 64'd3);      expect_pc("halt_ignore_jmp", 64'd5);
        drive(1, 4'd8, 0, 64'd11, 64'd22, 64'd33);   expect_pc("halt_reset", 64'd0);
        drive(0, 4'd8, 0, 64'd11, 64'd22, 64'd33);   expect_pc("resume_call", 64'd22);
`else
        drive(0, 4'd0, 0, 64'd112, 64'd100, 64'd17); expect_pc("halt_seq", 64'd112);
`endif
        drive(0, 4'd3, 1, 64'd1, 64'd9, 64'd9);      expect_pc("irmovq", 64'd1);
        drive(0, 4'd6, 0, 64'd11, 64'd9, 64'd9);     expect_pc("opq", 64'd11);
        drive(0, 4'd7, 1, 64'd1, 64'd2, 64'd3);      expect_pc("jxx_taken", 64'd2);
        drive(0, 4'd7, 0, 64'd1, 64'd2, 64'd3);      expect_pc("jxx_not_taken", 64'd1);
        drive(0, 4'd8, 0, 64'd11, 64'd22, 64'd33);   expect_pc("call", 64'd22);
        drive(0, 4'd9, 1, 64'd1, 64'd2, 64'd3);      expect_pc("ret", 64'd3);
        drive(0, 4'd7, 1, 64'd4, ones, 64'd3);       expect_pc("jxx_full_width", ones);
        drive(0, 4'd8, 1, 64'd11, 64'd22, 64'd33);   expect_pc("call_cnd_ignored", 64'd22);
        drive(0, 4'd12, 1, 64'd5, 64'd6, 64'd7);     expect_pc("invalid_12", 64'd22);
        drive(0, 4'd15, 0, ones, ones, ones);        expect_pc("invalid_15", 64'd22);
        drive(1, 4'd8, 0, 64'd11, 64'd22, 64'd33);   expect_pc("reset_over_call", 64'd0);

        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 99) < 3), 4'($urandom_range(0, 15)), 1'($urandom),
                  {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
